// File: rtl/rx_eng.sv
// rtl/rx_eng.sv - UART receive engine: synchronizer, frame FSM, byte/status registers.
// RX_MAJORITY_EN: each start/data/parity/stop decision is a 3-sample majority vote.
module rx_eng #(
  parameter int SYNC_STAGES = 2,
  parameter int K_SIM       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reads0,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic [3:0] baud_val,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam int          NS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [18:0] K_OVR = 19'(K_SIM);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t      state, state_nx;
  logic [NS-1:0] sync_q;
  logic        rxs;
  logic        bit_s;
  logic [18:0] k_tab, k, cnt, start_thr;
  logic [3:0]  idx, n_bits, sh_amt;
  logic [8:0]  shreg, frame;
  logic [7:0]  data_w;
  logic        par_rx, par_exp;
  logic        stop_q;
  logic        armed;
  logic        start_dec, tick, cnt_clr, shift_en, stop_en, done;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[NS-2:0], rx};
  end
  assign rxs = sync_q[NS-1];

`ifdef RX_MAJORITY_EN
  localparam logic [18:0] DEC_OFS = 19'd1;
  logic [1:0] rxs_hist;

  // Decision one cycle after the centre sample, voting over centre-1, centre, centre+1
  always_ff @(posedge clk) begin
    if (rst) rxs_hist <= 2'b11;
    else     rxs_hist <= {rxs_hist[0], rxs};
  end
  assign bit_s = (rxs & rxs_hist[0]) | (rxs & rxs_hist[1]) | (rxs_hist[0] & rxs_hist[1]);
`else
  localparam logic [18:0] DEC_OFS = 19'd0;
  assign bit_s = rxs;
`endif

  always_comb begin
    k_tab = 19'd868;
    case (baud_val)
      4'd0:  k_tab = 19'd333333;
      4'd1:  k_tab = 19'd83333;
      4'd2:  k_tab = 19'd41667;
      4'd3:  k_tab = 19'd20833;
      4'd4:  k_tab = 19'd10417;
      4'd5:  k_tab = 19'd5208;
      4'd6:  k_tab = 19'd2604;
      4'd7:  k_tab = 19'd1736;
      4'd8:  k_tab = 19'd868;
      4'd9:  k_tab = 19'd434;
      4'd10: k_tab = 19'd217;
      4'd11: k_tab = 19'd109;
      default: k_tab = 19'd868;
    endcase
  end

  assign k         = (K_SIM != 0) ? K_OVR : k_tab;
  assign start_thr = (k >> 1) + DEC_OFS;
  assign n_bits    = 4'd7 + {3'b000, eight} + {3'b000, pen};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Comparisons use >= so a mid-frame config change still drains back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!rxs && armed) state_nx = S_START;
      S_START: if (cnt >= start_thr) state_nx = bit_s ? S_IDLE : S_DATA;
      S_DATA:  if (cnt >= k - 19'd1 && idx >= n_bits - 4'd1) state_nx = S_STOP;
      S_STOP:  if (cnt >= k - 19'd1) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    start_dec = (state == S_START) && (cnt >= start_thr);
    tick      = ((state == S_DATA) || (state == S_STOP)) && (cnt >= k - 19'd1);
    cnt_clr   = (state == S_IDLE) || start_dec || tick;
    shift_en  = (state == S_DATA) && tick;
    stop_en   = (state == S_STOP) && tick;
    done      = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      stop_q <= 1'b1;
      armed  <= 1'b1;
    end else begin
      cnt <= cnt_clr ? 19'd0 : cnt + 19'd1;
      if (start_dec) begin
        idx   <= '0;
        shreg <= '0;
      end else if (shift_en) begin
        idx   <= idx + 4'd1;
        shreg <= {bit_s, shreg[8:1]};
      end
      if (stop_en) stop_q <= bit_s;
      // A stuck-low line must go high again before another start is accepted
      armed <= done ? rxs : (armed | rxs);
    end
  end

  assign sh_amt  = 4'd9 - n_bits;
  assign frame   = shreg >> sh_amt;
  assign data_w  = eight ? frame[7:0] : {1'b0, frame[6:0]};
  assign par_rx  = eight ? frame[8] : frame[7];
  assign par_exp = (^data_w) ^ ohel;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (done) begin
        rx_data <= data_w;
        perr    <= pen & (par_rx ^ par_exp);
        ferr    <= ~stop_q;
      end
      if (done)        rx_rdy <= 1'b1;
      else if (reads0) rx_rdy <= 1'b0;
      if (reads0)                ovf <= 1'b0;
      else if (done && rx_rdy)   ovf <= 1'b1;
    end
  end

endmodule
